// File: rtl/fft_pkg.sv
// Shared types, sizes and helpers for the 16-point FFT output reorder buffer.
package fft_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned N_POINTS_DEF   = 16;
  localparam int unsigned LOG2N          = $clog2(N_POINTS_DEF);

  // One complex sample as carried between butterfly stages.
  typedef struct packed {
    logic signed [DATA_WIDTH_DEF-1:0] r;
    logic signed [DATA_WIDTH_DEF-1:0] i;
  } cplx_t;

  // Lifecycle of one ping-pong bank.
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Reverse the LOG2N-bit index (bit b of the result is bit LOG2N-1-b of idx).
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] rev;
    rev = '0;
    for (int b = 0; b < int'(LOG2N); b++) begin
      rev[b] = idx[int'(LOG2N)-1-b];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame of complex-sample storage: single write port, asynchronous read port.
module fft_reorder_bank #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write; contents are not reset (stale data is never read before rewrite).
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// FFT output reorder buffer: accepts frames in bit-reversed order into two
// ping-pong banks and emits them in natural order with valid/ready on both sides.
// Optional build macro FFT_REORDER_BYPASS_EN adds bitrev_bypass, sampled at the
// first read of each frame, which passes the frame through in input order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned N_POINTS   = N_POINTS_DEF
) (
`ifdef FFT_REORDER_BYPASS_EN
  input  logic                        bitrev_bypass,
`endif
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_r,
  input  logic [DATA_WIDTH-1:0]       in_i,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_r,
  output logic [DATA_WIDTH-1:0]       out_i,
  output logic [$clog2(N_POINTS)-1:0] out_idx,
  output logic                        out_last
);

  localparam int unsigned AW       = $clog2(N_POINTS);
  localparam int unsigned SW       = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);

  bank_state_e           bank_st_q [2];
  bank_state_e           bank_st_d [2];
  logic                  wr_sel_q, wr_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [AW-1:0]         wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]         rd_cnt_q, rd_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_r_q, out_r_d;
  logic [DATA_WIDTH-1:0] out_i_q, out_i_d;
  logic [AW-1:0]         out_idx_q, out_idx_d;

  logic [1:0]    full_c;
  logic [1:0]    wr_hit;
  logic [1:0]    rd_hit;
  logic          wr_fire;
  logic          rd_load;
  logic          wr_last;
  logic          rd_last;
  logic [AW-1:0] rev_addr;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rdata0;
  logic [SW-1:0] rdata1;
  logic [SW-1:0] rd_word;

  // A bank blocks the writer from its last write until its last read.
  always_comb begin
    full_c = '0;
    for (int b = 0; b < 2; b++) begin
      full_c[b] = (bank_st_q[b] == BANK_FULL) || (bank_st_q[b] == BANK_DRAINING);
    end
  end

  assign in_ready = !rst && !full_c[wr_sel_q];
  assign wr_fire  = in_valid && in_ready;
  assign rd_load  = (!out_valid_q || out_ready) && full_c[rd_sel_q];
  assign wr_last  = (wr_cnt_q == LAST_IDX);
  assign rd_last  = (rd_cnt_q == LAST_IDX);
  assign wr_hit   = {wr_fire && wr_sel_q, wr_fire && !wr_sel_q};
  assign rd_hit   = {rd_load && rd_sel_q, rd_load && !rd_sel_q};

  // Bit-reversed read address for natural-order output.
  always_comb begin
    rev_addr = '0;
    for (int b = 0; b < int'(AW); b++) begin
      rev_addr[b] = rd_cnt_q[int'(AW)-1-b];
    end
  end

`ifdef FFT_REORDER_BYPASS_EN
  logic byp_q, byp_d;
  // Bypass mode is latched on the first read of a frame and held until the next frame.
  assign byp_d   = (rd_load && (rd_cnt_q == '0)) ? bitrev_bypass : byp_q;
  assign rd_addr = byp_d ? rd_cnt_q : rev_addr;
`else
  assign rd_addr = rev_addr;
`endif

  fft_reorder_bank #(.DEPTH(N_POINTS), .WIDTH(SW)) u_bank0 (
    .clk     (clk),
    .we_i    (wr_hit[0]),
    .waddr_i (wr_cnt_q),
    .wdata_i ({in_r, in_i}),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  fft_reorder_bank #(.DEPTH(N_POINTS), .WIDTH(SW)) u_bank1 (
    .clk     (clk),
    .we_i    (wr_hit[1]),
    .waddr_i (wr_cnt_q),
    .wdata_i ({in_r, in_i}),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

  assign rd_word = rd_sel_q ? rdata1 : rdata0;

  // Per-bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_d[b] = bank_st_q[b];
      case (bank_st_q[b])
        BANK_EMPTY:    if (wr_hit[b]) bank_st_d[b] = wr_last ? BANK_FULL : BANK_FILLING;
        BANK_FILLING:  if (wr_hit[b] && wr_last) bank_st_d[b] = BANK_FULL;
        BANK_FULL:     if (rd_hit[b]) bank_st_d[b] = rd_last ? BANK_EMPTY : BANK_DRAINING;
        BANK_DRAINING: if (rd_hit[b] && rd_last) bank_st_d[b] = BANK_EMPTY;
        default:       bank_st_d[b] = BANK_EMPTY;
      endcase
    end
  end

  // Write/read counters, bank selects and the output register.
  always_comb begin
    wr_sel_d    = wr_sel_q;
    wr_cnt_d    = wr_cnt_q;
    rd_sel_d    = rd_sel_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + AW'(1);
      if (wr_last) begin
        wr_cnt_d = '0;
        wr_sel_d = !wr_sel_q;
      end
    end

    if (rd_load) begin
      out_valid_d = 1'b1;
      out_r_d     = rd_word[SW-1 -: DATA_WIDTH];
      out_i_d     = rd_word[DATA_WIDTH-1:0];
      out_idx_d   = rd_cnt_q;
      out_last_d  = rd_last;
      rd_cnt_d    = rd_cnt_q + AW'(1);
      if (rd_last) begin
        rd_cnt_d = '0;
        rd_sel_d = !rd_sel_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; partial frames are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_sel_q     <= 1'b0;
      wr_cnt_q     <= '0;
      rd_sel_q     <= 1'b0;
      rd_cnt_q     <= '0;
      out_valid_q  <= 1'b0;
      out_r_q      <= '0;
      out_i_q      <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
`ifdef FFT_REORDER_BYPASS_EN
      byp_q        <= 1'b0;
`endif
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      wr_sel_q     <= wr_sel_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_sel_q     <= rd_sel_d;
      rd_cnt_q     <= rd_cnt_d;
      out_valid_q  <= out_valid_d;
      out_r_q      <= out_r_d;
      out_i_q      <= out_i_d;
      out_idx_q    <= out_idx_d;
      out_last_q   <= out_last_d;
`ifdef FFT_REORDER_BYPASS_EN
      byp_q        <= byp_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (frame-level reference model).
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int LG = 4;

  typedef struct packed {
    logic [LG-1:0] idx;
    logic          last;
    logic [DW-1:0] r;
    logic [DW-1:0] i;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_i;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;
  logic [LG-1:0] out_idx;
  logic          out_last;
`ifdef FFT_REORDER_BYPASS_EN
  logic          bitrev_bypass;
`endif

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
`ifdef FFT_REORDER_BYPASS_EN
    .bitrev_bypass (bitrev_bypass),
`endif
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  exp_t        exp_q[$];
  cplx_t       cur [N];
  int          cur_n    = 0;
  logic        frame_mode = 1'b0;
  logic        t1_mode    = 1'b0;
  logic        hold_pend  = 1'b0;
  logic [63:0] hold_val   = '0;
  int          pops       = 0;
  int          first_pop  = 0;
  int          last_pop   = 0;

  function automatic int brev(input int x);
    int y;
    int r;
    y = x;
    r = 0;
    for (int b = 0; b < LG; b++) begin
      r = r * 2 + (y % 2);
      y = y / 2;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // A completed frame: natural bin n was the bitrev(n)-th arrival (or the n-th in bypass).
  task automatic push_frame();
    exp_t e;
    int   pos;
    for (int n = 0; n < N; n++) begin
      pos    = frame_mode ? n : brev(n);
      e.idx  = LG'(n);
      e.last = (n == N - 1);
      e.r    = cur[pos].r;
      e.i    = cur[pos].i;
      exp_q.push_back(e);
    end
  endtask

  // One clock: drive at the falling edge, observe before the next rising edge.
  task automatic step(input logic s_rst, input logic iv, input cplx_t d, input logic ordy,
                      output logic acc);
    exp_t e;
    rst = s_rst; in_valid = iv; in_r = d.r; in_i = d.i; out_ready = ordy;
    #1;
    acc = 1'b0;
    if (s_rst) begin
      exp_q.delete();
      cur_n     = 0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        check("hold_stable", {out_valid, out_last, out_idx, out_r, out_i}, hold_val);
      if (in_valid && in_ready) begin
        acc = 1'b1;
        cur[cur_n] = d;
        cur_n++;
        if (cur_n == N) begin
          push_frame();
          cur_n = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("out_idx", out_idx, e.idx);
          check("out_data", {out_r, out_i}, {e.r, e.i});
          check("out_last", out_last, e.last);
          if (t1_mode) check("t1_r_is_3idx", out_r, 16'(3 * int'(out_idx)));
          if (pops == 0) first_pop = cyc;
          last_pop = cyc;
          pops++;
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = 64'({out_valid, out_last, out_idx, out_r, out_i});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, 1'b0, '0, ordy, a);
  endtask

  task automatic feed(input int n, input int pat, input logic ordy);
    int    k;
    int    guard;
    cplx_t d;
    logic  a;
    k = 0;
    guard = 0;
    while (k < n && guard < 4 * n + 64) begin
      if (pat == 1) begin
        d.r = 16'(brev(k) * 3);
        d.i = 16'(-k);
      end else begin
        d = cplx_t'($urandom);
      end
      step(1'b0, 1'b1, d, ordy, a);
      if (a) k++;
      guard++;
    end
    check("feed_count", k, n);
  endtask

  task automatic drain(input logic rnd);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 400) begin
      idle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", out_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic  a;
    int    ptr;
    int    g;
    cplx_t arr [48];

    rst = 1'b1; in_valid = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b0;
`ifdef FFT_REORDER_BYPASS_EN
    bitrev_bypass = 1'b0;
`endif
    @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", {out_r, out_i}, '0);
    check("rst_out_idx", out_idx, '0);
    check("rst_out_last", out_last, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Single frame, known pattern, latency from last accept.
    t1_mode = 1'b1;
    feed(16, 1, 1'b1);
    check("t1_lat_k1", out_valid, 1'b0);
    idle(1'b1);
    check("t1_lat_k2_valid", out_valid, 1'b1);
    check("t1_lat_k2_idx", out_idx, 0);
    drain(1'b0);
    t1_mode = 1'b0;

    // Four frames streamed back to back.
    pops = 0;
    for (int c = 0; c < 64; c++) begin
      check("t2_in_ready", in_ready, 1'b1);
      step(1'b0, 1'b1, cplx_t'($urandom), 1'b1, a);
    end
    drain(1'b0);
    check("t2_pops", pops, 64);
    check("t2_no_gap", last_pop - first_pop + 1, 64);

    // Consumer stalled: both banks fill, then release.
    for (int k = 0; k < 48; k++) arr[k] = cplx_t'($urandom);
    ptr = 0;
    for (int c = 0; c < 40; c++) begin
      if (ptr >= 32) check("t3_in_ready_low", in_ready, 1'b0);
      step(1'b0, 1'b1, arr[ptr], 1'b0, a);
      if (a) ptr++;
    end
    check("t3_accepted", ptr, 32);
    g = 0;
    while (ptr < 48 && g < 200) begin
      step(1'b0, 1'b1, arr[ptr], 1'b1, a);
      if (a) ptr++;
      g++;
    end
    check("t3_third_frame", ptr, 48);
    drain(1'b0);

    // Random input gaps and random consumer back-pressure.
    for (int k = 0; k < 48; k++) arr[k] = cplx_t'($urandom);
    ptr = 0; g = 0; pops = 0;
    while ((ptr < 48 || exp_q.size() != 0) && g < 1500) begin
      step(1'b0, (ptr < 48) && ($urandom_range(0, 3) != 0), arr[ptr % 48],
           1'($urandom_range(0, 1)), a);
      if (a) ptr++;
      g++;
    end
    check("t4_accepted", ptr, 48);
    check("t4_pops", pops, 48);
    drain(1'b1);

    // Reset mid-fill.
    feed(9, 0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, a);
    check("t5a_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("t5a_in_ready", in_ready, 1'b1);
    pops = 0;
    feed(16, 0, 1'b1);
    drain(1'b0);
    check("t5a_pops", pops, 16);

    // Reset mid-drain at idx 5.
    feed(16, 0, 1'b1);
    g = 0;
    while (!(out_valid && out_idx == 5) && g < 100) begin
      idle(1'b1);
      g++;
    end
    check("t5b_at_idx5", out_idx, 5);
    step(1'b1, 1'b0, '0, 1'b1, a);
    check("t5b_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("t5b_in_ready", in_ready, 1'b1);
    pops = 0;
    feed(16, 0, 1'b1);
    drain(1'b0);
    check("t5b_pops", pops, 16);

`ifdef FFT_REORDER_BYPASS_EN
    // Bypass frame then bit-reversed frame; mid-drain toggles must be ignored.
    frame_mode = 1'b1; bitrev_bypass = 1'b1; pops = 0;
    feed(16, 0, 1'b1);
    g = 0;
    while (pops < 4 && g < 100) begin idle(1'b1); g++; end
    bitrev_bypass = 1'b0;
    drain(1'b0);
    check("t6a_pops", pops, 16);
    frame_mode = 1'b0; pops = 0;
    feed(16, 0, 1'b1);
    g = 0;
    while (pops < 4 && g < 100) begin idle(1'b1); g++; end
    bitrev_bypass = 1'b1;
    drain(1'b0);
    bitrev_bypass = 1'b0;
    check("t6b_pops", pops, 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
